// File: rtl/genetic_eval_ctrl.sv
// Sequencer for the evolvable logic-element array: serial chromosome load, commit,
// then an exhaustive input sweep that scores array outputs against a target truth table.
module genetic_eval_ctrl #(
  parameter int unsigned ROW    = 3,
  parameter int unsigned COL    = 1,
  parameter int unsigned IN     = 3,
  parameter int unsigned OUT    = 1,
  parameter int unsigned SETTLE = 2,
  localparam int unsigned NV      = 1 << IN,
  localparam int unsigned NCELL   = ROW * COL,
  localparam int unsigned SEL_W   = (NCELL > 1) ? $clog2(NCELL) : 1,
  localparam int unsigned CHROM_W = NCELL * 16 + OUT * SEL_W,
  localparam int unsigned FIT_W   = $clog2(OUT * NV + 1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           reuse,
  input  logic                           cfg_valid,
  input  logic                           cfg_bit,
  output logic                           cfg_ready,
  input  logic [OUT*NV-1:0]              target,
  output logic [ROW-1:0][COL-1:0][15:0]  saidas_LE,
  output logic [OUT-1:0][SEL_W-1:0]      out_chrom,
  output logic [IN-1:0]                  inp,
  input  logic [OUT-1:0]                 circ_out,
  output logic                           busy,
  output logic                           done,
  output logic [FIT_W-1:0]               fitness
);

  localparam int unsigned CELL_W = NCELL * 16;
  localparam int unsigned SELS_W = OUT * SEL_W;
  localparam int unsigned BCNT_W = $clog2(CHROM_W + 1);
  localparam int unsigned HOLD_W = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_EVAL = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [CHROM_W-1:0]  shift_q;
  logic [BCNT_W-1:0]   bit_cnt_q;
  logic [HOLD_W-1:0]   hold_q;

  logic                start_ok_c;
  logic                accept_c;
  logic                last_bit_c;
  logic                commit_c;
  logic                sample_c;
  logic                last_vec_c;
  logic [NV-1:0]       tvec_c;
  logic [FIT_W-1:0]    match_cnt_c;

  logic                busy_d;
  logic                done_d;
  logic                cfg_ready_d;

  assign start_ok_c = ((state_q == S_IDLE) || (state_q == S_DONE)) && start;
  assign accept_c   = (state_q == S_LOAD) && cfg_valid && cfg_ready;
  assign last_bit_c = accept_c && (bit_cnt_q == BCNT_W'(CHROM_W - 1));
  assign commit_c   = (state_q == S_LOAD) && (bit_cnt_q == BCNT_W'(CHROM_W));
  assign sample_c   = (state_q == S_EVAL) && (hold_q == HOLD_W'(SETTLE));
  assign last_vec_c = (inp == IN'(NV - 1));

  // Number of outputs agreeing with the target for the vector currently on inp
  always_comb begin
    tvec_c      = '0;
    match_cnt_c = '0;
    for (int k = 0; k < OUT; k++) begin
      tvec_c      = target[k*NV +: NV];
      match_cnt_c = match_cnt_c + FIT_W'(circ_out[k] ~^ tvec_c[inp]);
    end
  end

  // State register; status outputs are registered alongside it
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      cfg_ready <= 1'b0;
    end else begin
      state_q   <= state_d;
      busy      <= busy_d;
      done      <= done_d;
      cfg_ready <= cfg_ready_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = reuse ? S_EVAL : S_LOAD;
      end
      S_LOAD: begin
        if (commit_c) state_d = S_EVAL;
      end
      S_EVAL: begin
        if (sample_c && last_vec_c) state_d = S_DONE;
      end
      S_DONE: begin
        if (start) state_d = reuse ? S_EVAL : S_LOAD;
        else       state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Status decode from the upcoming state; ready drops once the last bit is taken
  always_comb begin
    busy_d      = 1'b0;
    done_d      = 1'b0;
    cfg_ready_d = 1'b0;
    busy_d      = (state_d == S_LOAD) || (state_d == S_EVAL);
    done_d      = (state_d == S_DONE);
    cfg_ready_d = (state_d == S_LOAD) && !last_bit_c;
  end

  // Datapath: shadow shift register, commit, vector sweep and scoring
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q   <= '0;
      bit_cnt_q <= '0;
      hold_q    <= '0;
      saidas_LE <= '0;
      out_chrom <= '0;
      inp       <= '0;
      fitness   <= '0;
    end else begin
      if (start_ok_c) begin
        fitness   <= '0;
        bit_cnt_q <= '0;
        inp       <= '0;
        hold_q    <= '0;
      end
      if (accept_c) begin
        shift_q   <= {shift_q[CHROM_W-2:0], cfg_bit};
        bit_cnt_q <= bit_cnt_q + BCNT_W'(1);
      end
      if (commit_c) begin
        saidas_LE <= shift_q[CHROM_W-1 -: CELL_W];
        out_chrom <= shift_q[SELS_W-1:0];
        inp       <= '0;
        hold_q    <= '0;
      end
      if (state_q == S_EVAL) begin
        if (sample_c) begin
          fitness <= fitness + match_cnt_c;
          hold_q  <= '0;
          inp     <= last_vec_c ? '0 : inp + IN'(1);
        end else begin
          hold_q  <= hold_q + HOLD_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_genetic_eval_ctrl.sv
// Self-checking bench for genetic_eval_ctrl with a behavioural array model whose
// outputs are only valid once an input vector has been stable for SETTLE edges.
module tb_genetic_eval_ctrl;

  localparam int CW     = 50;
  localparam int NV     = 8;
  localparam int SETTLE = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  start;
  logic                  reuse;
  logic                  cfg_valid;
  logic                  cfg_bit;
  logic                  cfg_ready;
  logic [7:0]            target;
  logic [2:0][0:0][15:0] saidas_LE;
  logic [0:0][1:0]       out_chrom;
  logic [2:0]            inp;
  logic [0:0]            circ_out;
  logic                  busy;
  logic                  done;
  logic [3:0]            fitness;

  int checks = 0;
  int errors = 0;
  logic [CW-1:0] cur_chrom;

  always #5 clk = ~clk;

  genetic_eval_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .reuse     (reuse),
    .cfg_valid (cfg_valid),
    .cfg_bit   (cfg_bit),
    .cfg_ready (cfg_ready),
    .target    (target),
    .saidas_LE (saidas_LE),
    .out_chrom (out_chrom),
    .inp       (inp),
    .circ_out  (circ_out),
    .busy      (busy),
    .done      (done),
    .fitness   (fitness)
  );

  // Array model: cell truth-table index is the input vector; output wrong until settled
  logic [2:0]  last_inp;
  int          age = 0;
  logic [15:0] sel_tt;
  logic        good;

  always @(posedge clk) begin
    if (inp !== last_inp) age <= 1;
    else if (age < 1000)  age <= age + 1;
    last_inp <= inp;
  end

  always_comb begin
    sel_tt = '0;
    case (out_chrom[0])
      2'd0:    sel_tt = saidas_LE[0][0];
      2'd1:    sel_tt = saidas_LE[1][0];
      2'd2:    sel_tt = saidas_LE[2][0];
      default: sel_tt = '0;
    endcase
    good        = sel_tt[{1'b0, inp}];
    circ_out[0] = (age >= SETTLE) ? good : ~good;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference score: selected cell's truth table vs target, vector by vector
  function automatic int ref_fit(input logic [CW-1:0] ch, input logic [7:0] tg);
    int          sel;
    int          n;
    logic [15:0] tt;
    sel = int'(ch[1:0]);
    n   = 0;
    tt  = '0;
    if (sel < 3) tt = ch[2 + 16*sel +: 16];
    for (int v = 0; v < NV; v++) begin
      if (tt[v] == tg[v]) n++;
    end
    return n;
  endfunction

  task automatic done_drop();
    @(negedge clk);
    check("done_pulse_once", 64'(done), 64'(0));
    check("idle_not_busy", 64'(busy), 64'(0));
  endtask

  task automatic load_run(input logic [CW-1:0] ch, input logic [7:0] tg, input bit gaps);
    int idx;
    int guard;
    int n;
    bit presented;
    bit rdy;
    @(negedge clk);
    target = tg;
    start  = 1'b1;
    reuse  = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check("load_ready", 64'(cfg_ready), 64'(1));
    check("load_busy", 64'(busy), 64'(1));
    idx       = CW - 1;
    guard     = 0;
    presented = 1'b0;
    rdy       = 1'b0;
    forever begin
      if (presented && rdy) idx--;
      if (idx < 0 || guard > 1000) break;
      cfg_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      cfg_bit   = ch[idx];
      rdy       = cfg_ready;
      presented = cfg_valid;
      if (gaps) begin
        start = 1'($urandom_range(0, 1));
        reuse = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      guard++;
    end
    cfg_valid = 1'b0;
    start     = 1'b0;
    check("load_all_bits", 64'(idx < 0), 64'(1));
    check("ready_drop", 64'(cfg_ready), 64'(0));
    check("cfg_stable_in_load", 64'({saidas_LE, out_chrom}), 64'(cur_chrom));
    n = 0;
    while (!done && n < 80) begin
      @(negedge clk);
      n++;
    end
    check("load_eval_latency", 64'(n), 64'(25));
    check("cfg_cells", 64'(saidas_LE), 64'(ch[CW-1:2]));
    check("cfg_sel", 64'(out_chrom), 64'(ch[1:0]));
    cur_chrom = ch;
    check("load_fitness", 64'(fitness), 64'(ref_fit(ch, tg)));
  endtask

  task automatic reuse_run(input logic [7:0] tg);
    int lat;
    bit rdy_seen;
    @(negedge clk);
    target   = tg;
    start    = 1'b1;
    reuse    = 1'b1;
    lat      = 0;
    rdy_seen = 1'b0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) start = 1'b0;
      if (cfg_ready) rdy_seen = 1'b1;
      if (lat <= 24 && !done) check($sformatf("inp_step_%0d", lat), 64'(inp), 64'((lat - 1) / 3));
    end while (!done && lat < 60);
    check("reuse_latency", 64'(lat), 64'(25));
    check("reuse_no_load", 64'(rdy_seen), 64'(0));
    check("reuse_fitness", 64'(fitness), 64'(ref_fit(cur_chrom, tg)));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [CW-1:0] ch;
    logic [7:0]    tg;
    int            n;
    rst       = 1'b1;
    start     = 1'b0;
    reuse     = 1'b0;
    cfg_valid = 1'b0;
    cfg_bit   = 1'b0;
    target    = '0;
    cur_chrom = '0;
    repeat (3) @(negedge clk);
    check("rst_fitness", 64'(fitness), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_ready", 64'(cfg_ready), 64'(0));
    check("rst_inp", 64'(inp), 64'(0));
    check("rst_cells", 64'(saidas_LE), 64'(0));
    check("rst_sel", 64'(out_chrom), 64'(0));
    rst = 1'b0;

    // Serial bits outside LOAD must not start anything
    cfg_valid = 1'b1;
    cfg_bit   = 1'b1;
    repeat (4) @(negedge clk);
    check("idle_ignores_cfg", 64'(busy), 64'(0));
    cfg_valid = 1'b0;

    ch = {48'hFFFF_FFFF_FFFF, 2'b00};
    load_run(ch, 8'hFF, 1'b0);
    done_drop();
    reuse_run(8'hAA);
    done_drop();
    repeat (3) @(negedge clk);
    check("fitness_holds_idle", 64'(fitness), 64'(4));

    load_run(ch, 8'h00, 1'b1);
    done_drop();

    ch = {32'($urandom), 16'hAAAA, 2'b00};
    load_run(ch, 8'hAA, 1'b0);
    done_drop();

    for (int i = 0; i < 4; i++) begin
      ch = CW'({$urandom, $urandom});
      tg = 8'($urandom);
      load_run(ch, tg, 1'($urandom_range(0, 1)));
      done_drop();
      reuse_run(8'($urandom));
      done_drop();
    end

    // start held during DONE restarts immediately with a cleared score
    reuse_run(8'($urandom));
    tg     = 8'($urandom);
    target = tg;
    start  = 1'b1;
    reuse  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("restart_busy", 64'(busy), 64'(1));
    check("restart_done_low", 64'(done), 64'(0));
    check("restart_fit_clear", 64'(fitness), 64'(0));
    n = 1;
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("restart_latency", 64'(n), 64'(25));
    check("restart_fitness", 64'(fitness), 64'(ref_fit(cur_chrom, tg)));
    done_drop();

    // Reset in the middle of the sweep
    @(negedge clk);
    target = 8'h3C;
    start  = 1'b1;
    reuse  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (inp != 3'd5 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("reach_v5", 64'(inp), 64'(5));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_fitness", 64'(fitness), 64'(0));
    check("midrst_inp", 64'(inp), 64'(0));
    check("midrst_cells", 64'(saidas_LE), 64'(0));
    check("midrst_sel", 64'(out_chrom), 64'(0));
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_done", 64'(done), 64'(0));
    check("midrst_ready", 64'(cfg_ready), 64'(0));
    @(negedge clk);
    check("midrst_idle", 64'(busy), 64'(0));
    cur_chrom = '0;
    reuse_run(8'h00);
    check("zero_cfg_fitness", 64'(fitness), 64'(8));
    done_drop();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
